// File: rtl/audio_pkg.sv
// Shared audio-path types and constants for the PCM output stage.
package audio_pkg;

    localparam int SAMPLE_BITS_DEF = 24;
    localparam int MCLK_PER_FS     = 256;

    typedef logic signed [SAMPLE_BITS_DEF-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit/frame timing: divides mclk into BCLK and counts bits within a frame.
module i2s_clkgen
    import audio_pkg::*;
#(
    parameter int SLOT_BITS = 32,
    parameter int MCLK_DIV  = 4,
    parameter int DIV_W     = $clog2(MCLK_DIV),
    parameter int BIT_W     = $clog2(2*SLOT_BITS)
) (
    input  logic             mclk,
    input  logic             rst,
    output logic             bclk,
    output logic             lrclk,
    output logic [BIT_W-1:0] bit_cnt,
    output logic             fall_tick,
    output logic             frame_last
);

    logic [DIV_W-1:0] div_cnt;

    // BCLK falls (and the next bit starts) on the edge where div_cnt wraps
    assign fall_tick  = (div_cnt == DIV_W'(MCLK_DIV-1));
    assign frame_last = fall_tick && (bit_cnt == BIT_W'(2*SLOT_BITS-1));
    assign bclk       = div_cnt[DIV_W-1];
    assign lrclk      = bit_cnt[BIT_W-1];

    // mclk divider, wraps once per BCLK period
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (fall_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // bit position within the stereo frame, advances on each BCLK falling edge
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
        end else if (frame_last) begin
            bit_cnt <= '0;
        end else if (fall_tick) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx_module.sv
// Philips I2S transmitter: latches one stereo frame per sample period and
// shifts it out MSB first, one BCLK after each LRCLK edge, zero-padded.
module i2s_tx_module
    import audio_pkg::*;
#(
    parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
    parameter int SLOT_BITS   = 32,
    parameter int MCLK_DIV    = 4
) (
    input  logic                          mclk,
    input  logic                          rst,
    input  logic signed [SAMPLE_BITS-1:0] s_left,
    input  logic signed [SAMPLE_BITS-1:0] s_right,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          underrun
);

    localparam int BIT_W = $clog2(2*SLOT_BITS);
    localparam int K_W   = BIT_W - 1;

    // Frame must exactly fill one sample period, and the word must leave
    // room for the leading I2S delay bit.
    if (MCLK_DIV*2*SLOT_BITS != MCLK_PER_FS) begin : g_bad_ratio
        $error("i2s_tx_module: MCLK_DIV*2*SLOT_BITS must equal %0d", MCLK_PER_FS);
    end
    if (SAMPLE_BITS < 1 || SAMPLE_BITS > SLOT_BITS-1) begin : g_bad_width
        $error("i2s_tx_module: SAMPLE_BITS must be in 1..SLOT_BITS-1");
    end
    if (MCLK_DIV < 2 || (MCLK_DIV & (MCLK_DIV-1)) != 0) begin : g_bad_div
        $error("i2s_tx_module: MCLK_DIV must be a power of two >= 2");
    end

    logic [BIT_W-1:0]              bit_cnt;
    logic [BIT_W-1:0]              bit_nxt;
    logic [K_W-1:0]                k_nxt;
    logic                          lr_nxt;
    logic                          fall_tick;
    logic                          frame_last;
    logic signed [SAMPLE_BITS-1:0] shadow_l;
    logic signed [SAMPLE_BITS-1:0] shadow_r;

    // Bit k of a slot: k=0 is the I2S delay bit, 1..SAMPLE_BITS carry the
    // word MSB first, anything beyond is padding.
    function automatic logic slot_bit(input logic [SAMPLE_BITS-1:0] word,
                                      input logic [K_W-1:0]         k);
        logic b;
        b = 1'b0;
        for (int i = 0; i < SAMPLE_BITS; i++) begin
            if (int'(k) == SAMPLE_BITS - i) begin
                b = word[i];
            end
        end
        return b;
    endfunction

    i2s_clkgen #(
        .SLOT_BITS (SLOT_BITS),
        .MCLK_DIV  (MCLK_DIV)
    ) u_clkgen (
        .mclk       (mclk),
        .rst        (rst),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .bit_cnt    (bit_cnt),
        .fall_tick  (fall_tick),
        .frame_last (frame_last)
    );

    // The frame length is a power of two, so the increment wraps naturally
    assign bit_nxt = bit_cnt + 1'b1;
    assign k_nxt   = bit_nxt[K_W-1:0];
    assign lr_nxt  = bit_nxt[BIT_W-1];
    assign s_ready = frame_last;

    // Capture a whole frame at the boundary; a missing frame becomes silence
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            shadow_l <= '0;
            shadow_r <= '0;
        end else if (frame_last) begin
            shadow_l <= s_valid ? s_left  : '0;
            shadow_r <= s_valid ? s_right : '0;
        end
    end

    // Serial data changes only on the BCLK falling edge, for the bit now starting
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            sdata <= 1'b0;
        end else if (fall_tick) begin
            sdata <= slot_bit(lr_nxt ? shadow_r : shadow_l, k_nxt);
        end
    end

    // Flag a frame boundary that found no data waiting
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            underrun <= 1'b0;
        end else begin
            underrun <= frame_last && !s_valid;
        end
    end

endmodule
